// File: rtl/data_sram_responder_pkg.sv
// Shared MMIO map for the data-port responder: window offsets and TX_STATUS bit layout.
// Imported by the RTL, CPU test programs and the bench.
package data_sram_responder_pkg;

    localparam logic [15:0] OffLed      = 16'hF000;
    localparam logic [15:0] OffTimer    = 16'hF010;
    localparam logic [15:0] OffTxData   = 16'hF020;
    localparam logic [15:0] OffTxStatus = 16'hF024;

    localparam int unsigned StatFullBit  = 0;
    localparam int unsigned StatEmptyBit = 1;
    localparam int unsigned StatOvfBit   = 2;
    localparam int unsigned StatCountLsb = 8;

endpackage

// File: rtl/data_sram_responder_tx_fifo.sv
// Byte transmit FIFO: circular buffer with registered head, no fall-through.
// Callers must not push when full without a simultaneous pop, nor pop when empty.
module data_sram_responder_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  logic [7:0]      i_push_data,
    input  logic            i_pop,
    output logic [7:0]      o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [CntW-1:0] o_count
);

    logic [7:0]      r_mem [DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    // Storage is not reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (!reset && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/data_sram_responder.sv
// Data-port responder for the single-cycle miniCPU: word RAM plus an MMIO window holding
// LED, free-running timer and a byte TX FIFO. Reads are combinational; writes commit at the edge.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_BASE  = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]           r_ram [2**RAM_ADDR_W];
    logic [15:0]           r_led;
    logic [31:0]           r_timer;
    logic                  r_ovf;

    logic                  w_mmio_sel;
    logic [15:0]           w_off;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic                  w_wr_ok;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push_ok;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_ovf_clr;
    logic                  w_full;
    logic                  w_empty;
    logic [CntW-1:0]       w_count;
    logic [31:0]           w_status;

    assign w_mmio_sel = (data_sram_addr[31:16] == MMIO_BASE);
    assign w_off      = data_sram_addr[15:0];
    assign w_ram_idx  = data_sram_addr[RAM_ADDR_W+1:2];
    assign w_wr_ok    = data_sram_we && !reset;

    assign w_pop      = tx_valid && tx_ready;
    assign w_push_req = w_wr_ok && w_mmio_sel && (w_off == OffTxData);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push_ok  = !w_full || w_pop;
    assign w_push     = w_push_req && w_push_ok;
    assign w_drop     = w_push_req && !w_push_ok;
    assign w_ovf_clr  = w_wr_ok && w_mmio_sel && (w_off == OffTxStatus) && data_sram_wdata[2];

    always_ff @(posedge clk) begin
        if (w_wr_ok && !w_mmio_sel) begin
            r_ram[w_ram_idx] <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led   <= '0;
            r_timer <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_mmio_sel && data_sram_we && (w_off == OffLed)) begin
                r_led <= data_sram_wdata[15:0];
            end
            if (w_mmio_sel && data_sram_we && (w_off == OffTimer)) begin
                r_timer <= data_sram_wdata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
            // A drop wins over a same-cycle clear so the loss is never hidden.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    data_sram_responder_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (data_sram_wdata[7:0]),
        .i_pop       (w_pop),
        .o_head      (tx_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_comb begin
        w_status                          = '0;
        w_status[StatFullBit]             = w_full;
        w_status[StatEmptyBit]            = w_empty;
        w_status[StatOvfBit]              = r_ovf;
        w_status[StatCountLsb +: 8]       = 8'(w_count);
    end

    always_comb begin
        data_sram_rdata = '0;
        if (w_mmio_sel) begin
            case (w_off)
                OffLed:      data_sram_rdata = {16'h0000, r_led};
                OffTimer:    data_sram_rdata = r_timer;
                OffTxStatus: data_sram_rdata = w_status;
                default:     data_sram_rdata = '0;
            endcase
        end else begin
            data_sram_rdata = r_ram[w_ram_idx];
        end
    end

    assign led_out  = r_led;
    assign tx_valid = !w_empty;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed test-plan checks plus randomized traffic compared
// every cycle against a queue/array model of the memory map.
module tb_data_sram_responder;
    import data_sram_responder_pkg::*;

    localparam logic [15:0] Base  = 16'hbfaf;
    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [15:0] led_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led_out         (led_out),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready)
    );

    initial forever #5 clk = ~clk;

    // Reference model
    bit [31:0] m_ram [1024];
    bit        m_ram_ok [1024];
    bit [15:0] m_led;
    bit [31:0] m_timer;
    bit        m_ovf;
    bit [7:0]  m_q [$];
    bit        m_known = 1'b0;

    function automatic bit [31:0] model_rd(input bit [31:0] a, output bit known);
        bit [31:0] s;
        known = 1'b1;
        if (a[31:16] == Base) begin
            s = 32'h0;
            if (a[15:0] == OffLed) return {16'h0, m_led};
            if (a[15:0] == OffTimer) return m_timer;
            if (a[15:0] == OffTxStatus) begin
                s[0]    = (m_q.size() == Depth);
                s[1]    = (m_q.size() == 0);
                s[2]    = m_ovf;
                s[15:8] = 8'(m_q.size());
            end
            return s;
        end
        known = m_ram_ok[a[11:2]];
        return m_ram[a[11:2]];
    endfunction

    always @(posedge clk) begin
        bit pop, preq, ok;
        if (reset) begin
            m_led = 0; m_timer = 0; m_ovf = 0; m_q.delete(); m_known = 1'b1;
        end else begin
            pop  = (m_q.size() != 0) && tx_ready;
            preq = we && addr[31:16] == Base && addr[15:0] == OffTxData;
            ok   = (m_q.size() < Depth) || pop;
            if (pop) void'(m_q.pop_front());
            if (preq && ok) m_q.push_back(wdata[7:0]);
            if (preq && !ok) m_ovf = 1'b1;
            else if (we && addr[31:16] == Base && addr[15:0] == OffTxStatus && wdata[2])
                m_ovf = 1'b0;
            if (we && addr[31:16] == Base && addr[15:0] == OffTimer) m_timer = wdata;
            else m_timer = m_timer + 1;
            if (we && addr[31:16] == Base && addr[15:0] == OffLed) m_led = wdata[15:0];
            if (we && addr[31:16] != Base) begin
                m_ram[addr[11:2]]    = wdata;
                m_ram_ok[addr[11:2]] = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled with inputs stable.
    always @(negedge clk) begin
        bit        k;
        bit [31:0] e;
        if (m_known) begin
            e = model_rd(addr, k);
            if (k) chk("model_rdata", rdata, e);
            chk("model_led", {16'h0, led_out}, {16'h0, m_led});
            chk("model_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
            if (m_q.size() != 0) chk("model_txdata", {24'h0, tx_data}, {24'h0, m_q[0]});
        end
    end

    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy);
        @(posedge clk);
        #1;
        we = w; addr = a; wdata = d; tx_ready = rdy;
        @(negedge clk);
    endtask

    function automatic logic [31:0] mm(input logic [15:0] off);
        return {Base, off};
    endfunction

    initial begin
        logic [31:0] a;
        // Reset
        op(0, 32'h0, 0, 0);
        op(0, 32'h0, 0, 0);
        @(posedge clk); #1 reset = 1'b0;
        op(0, mm(OffTxStatus), 0, 0);
        chk("rst_status", rdata, 32'h0000_0002);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);

        // RAM
        op(1, 32'h1c00_0008, 32'h1234_5678, 0);
        op(0, 32'h1c00_0008, 0, 0);
        chk("ram_rd", rdata, 32'h1234_5678);
        op(0, 32'h1c00_000b, 0, 0);
        chk("ram_rd_lowbits", rdata, 32'h1234_5678);

        // LED and timer
        op(1, mm(OffLed), 32'hABCD_1234, 0);
        op(0, mm(OffLed), 0, 0);
        chk("led_out", {16'h0, led_out}, 32'h1234);
        chk("led_rd", rdata, 32'h0000_1234);
        op(1, mm(OffTimer), 32'hFFFF_FFFE, 0);
        op(0, mm(OffTimer), 0, 0);
        chk("timer0", rdata, 32'hFFFF_FFFE);
        op(0, mm(OffTimer), 0, 0);
        chk("timer1", rdata, 32'hFFFF_FFFF);
        op(0, mm(OffTimer), 0, 0);
        chk("timer_wrap", rdata, 32'h0);

        // Fill, overflow, clear
        for (int i = 0; i < 4; i++) op(1, mm(OffTxData), 32'h41 + i, 0);
        op(0, mm(OffTxStatus), 0, 0);
        chk("fill_status", rdata, 32'h0000_0401);
        op(1, mm(OffTxData), 32'h45, 0);
        op(0, mm(OffTxStatus), 0, 0);
        chk("ovf_set", rdata, 32'h0000_0405);
        op(1, mm(OffTxStatus), 32'h4, 0);
        op(0, mm(OffTxStatus), 0, 0);
        chk("ovf_clr", rdata, 32'h0000_0401);

        // Drain
        for (int i = 0; i < 4; i++) begin
            op(0, mm(OffTxStatus), 0, 1);
            chk("drain_data", {24'h0, tx_data}, 32'h41 + i);
            chk("drain_valid", {31'h0, tx_valid}, 32'h1);
        end
        op(0, mm(OffTxStatus), 0, 1);
        chk("drain_empty_valid", {31'h0, tx_valid}, 32'h0);
        chk("drain_empty_status", rdata, 32'h0000_0002);

        // Push into a full FIFO while the head leaves
        for (int i = 0; i < 4; i++) op(1, mm(OffTxData), 32'h61 + i, 0);
        op(1, mm(OffTxData), 32'h55, 1);
        op(0, mm(OffTxStatus), 0, 0);
        chk("full_push_status", rdata, 32'h0000_0401);
        for (int i = 0; i < 4; i++) op(0, 32'h1c00_0000, 0, 1);
        chk("full_push_last", {24'h0, tx_data}, 32'h55);

        // Reset mid-operation
        op(1, 32'h1c00_0100, 32'hCAFE_F00D, 0);
        for (int i = 0; i < 3; i++) op(1, mm(OffTxData), 32'h70 + i, 0);
        op(1, mm(OffLed), 32'h0000_00FF, 0);
        @(posedge clk); #1 reset = 1'b1; we = 1'b1; addr = mm(OffLed); wdata = 32'h5A5A;
        @(posedge clk); #1 reset = 1'b0; we = 1'b0;
        op(0, mm(OffTxStatus), 0, 0);
        chk("rst_mid_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_mid_status", rdata, 32'h0000_0002);
        chk("rst_mid_led", {16'h0, led_out}, 32'h0);
        op(0, 32'h1c00_0100, 0, 0);
        chk("rst_mid_ram", rdata, 32'hCAFE_F00D);

        // Randomized traffic, checked every cycle by the model comparator
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0: a = mm(OffLed);
                1: a = mm(OffTimer);
                2, 3: a = mm(OffTxData);
                4: a = mm(OffTxStatus);
                5: a = mm(16'($urandom));
                default: begin
                    a = $urandom;
                    if (a[31:16] == Base) a[31] = ~a[31];
                    a[11:2] = 10'($urandom_range(0, 31));
                end
            endcase
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk); #1 reset = 1'b1;
                we = $urandom_range(0, 1) == 1; addr = a; wdata = $urandom;
                @(posedge clk); #1 reset = 1'b0;
            end else begin
                op($urandom_range(0, 1) == 1, a,
                   ($urandom_range(0, 3) == 0) ? 32'h4 : $urandom,
                   $urandom_range(0, 2) == 0);
            end
        end

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
